// File: rtl/cr_cpu_pkg.sv
// rtl/cr_cpu_pkg.sv - shared CR-CPU widths and fetch-stage state encodings
//
// Purpose: common constants imported by the CR-CPU pipeline stages.
//   CR_ADDR_WIDTH / CR_DATA_WIDTH : default PC and instruction widths
//   FETCH_CNT_W                   : read-latency counter width (latency 1..4)
//   FS_IDLE/FS_ISSUE/FS_WAIT/FS_HOLD : fetch FSM state codes
package cr_cpu_pkg;

   localparam int CR_ADDR_WIDTH = 16;
   localparam int CR_DATA_WIDTH = 16;
   localparam int FETCH_CNT_W   = $clog2(4);

   typedef logic [1:0] fetch_state_t;

   localparam logic [1:0] FS_IDLE  = 2'd0;
   localparam logic [1:0] FS_ISSUE = 2'd1;
   localparam logic [1:0] FS_WAIT  = 2'd2;
   localparam logic [1:0] FS_HOLD  = 2'd3;

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - CR-CPU fetch stage between PC/RAM and decode
//
// Purpose: reads the instruction at pc_in from a pipelined RAM, waits out the
// read latency, and holds the word for decode with a valid/ready handshake.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   pc_in                : current PC
//   fetch_en             : permit new fetches
//   flush                : discard in-flight/held instruction
//   ram_addr, ram_rd     : RAM read address (registered) and one-cycle strobe
//   ram_rd_data          : RAM data, valid READ_LATENCY cycles after ram_rd
//   ir_out, ir_pc        : fetched instruction and its address
//   ir_valid, ir_ready   : handshake with decode
//   pc_inc               : advance-PC pulse on acceptance
module instruction_fetch
   import cr_cpu_pkg::*;
#(
   parameter int ADDR_WIDTH   = CR_ADDR_WIDTH,
   parameter int DATA_WIDTH   = CR_DATA_WIDTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic                  fetch_en,
   input  logic                  flush,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] ir_out,
   output logic [ADDR_WIDTH-1:0] ir_pc,
   output logic                  ir_valid,
   input  logic                  ir_ready,
   output logic                  pc_inc
);

   localparam logic [FETCH_CNT_W-1:0] CNT_LOAD = FETCH_CNT_W'(READ_LATENCY - 1);

   fetch_state_t            r_state;
   fetch_state_t            w_next;
   logic [FETCH_CNT_W-1:0]  r_cnt;
   logic [ADDR_WIDTH-1:0]   r_ram_addr;
   logic [ADDR_WIDTH-1:0]   r_ir_pc;
   logic [DATA_WIDTH-1:0]   r_ir_out;
   logic                    w_capture;
   logic                    w_accept;

   // Capture only on the last wait cycle of the current request; a flush in
   // that cycle drops the word so an aborted read never reaches ir_out.
   assign w_capture = !flush && (r_state == FS_WAIT) && (r_cnt == '0);
   assign w_accept  = !flush && (r_state == FS_HOLD) && ir_ready;

   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = fetch_en ? FS_ISSUE : FS_IDLE;
      end else begin
         case (r_state)
            FS_IDLE:  if (fetch_en) w_next = FS_ISSUE;
            FS_ISSUE: w_next = FS_WAIT;
            FS_WAIT:  if (r_cnt == '0) w_next = FS_HOLD;
            FS_HOLD:  if (ir_ready) w_next = fetch_en ? FS_ISSUE : FS_IDLE;
            default:  w_next = FS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= FS_IDLE;
         r_cnt      <= '0;
         r_ram_addr <= '0;
         r_ir_pc    <= '0;
         r_ir_out   <= '0;
      end else begin
         r_state <= w_next;
         // Every entry into ISSUE (including re-entry after a flush) samples
         // pc_in, which after an accept already reflects the pc_inc pulse.
         if (w_next == FS_ISSUE) begin
            r_ram_addr <= pc_in;
         end
         if ((r_state == FS_ISSUE) && (w_next == FS_WAIT)) begin
            r_cnt <= CNT_LOAD;
         end else if ((r_state == FS_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_capture) begin
            r_ir_out <= ram_rd_data;
            r_ir_pc  <= r_ram_addr;
         end
      end
   end

   // Strobe and valid are state decodes, so reset clears them immediately.
   assign ram_rd   = (r_state == FS_ISSUE);
   assign ir_valid = (r_state == FS_HOLD);
   assign pc_inc   = w_accept;
   assign ram_addr = r_ram_addr;
   assign ir_out   = r_ir_out;
   assign ir_pc    = r_ir_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch at latencies 1, 2 and 3
module tb_instruction_fetch;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [3];
   logic        fen   [3];
   logic        fl    [3];
   logic        rdy   [3];
   logic [15:0] pc    [3];
   logic        pcm   [3];
   logic [15:0] ram_addr [3];
   logic        ram_rd   [3];
   logic [15:0] rdata    [3];
   logic [15:0] ir_out   [3];
   logic [15:0] ir_pc    [3];
   logic        ir_valid [3];
   logic        pc_inc   [3];
   logic [15:0] mem [3][256];

   logic [33:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   // instance 0: latency 1, instance 1: latency 2, instance 2: latency 3
   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int LAT = k + 1;
      logic [15:0] pipe [4];

      instruction_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .READ_LATENCY(LAT)) u_dut (
         .clk(clk), .reset(rst[k]), .pc_in(pc[k]), .fetch_en(fen[k]), .flush(fl[k]),
         .ram_addr(ram_addr[k]), .ram_rd(ram_rd[k]), .ram_rd_data(rdata[k]),
         .ir_out(ir_out[k]), .ir_pc(ir_pc[k]), .ir_valid(ir_valid[k]),
         .ir_ready(rdy[k]), .pc_inc(pc_inc[k])
      );

      always @(posedge clk) begin
         pipe[0] <= ram_rd[k] ? mem[k][ram_addr[k][7:0]] : 16'h0BAD;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata[k] = pipe[LAT-1];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic to_cycle();
      @(posedge clk);
      #1;
   endtask

   // waits to mid-cycle and advances the PC model on a pc_inc pulse
   task automatic mid(input int k);
      @(negedge clk);
      if (pcm[k] && pc_inc[k]) pc[k] = pc[k] + 16'd1;
   endtask

   task automatic push(input int k, input logic [15:0] d, input logic [15:0] a);
      exp_q.push_back({2'(k), d, a});
   endtask

   // monitor: every accepted instruction must match the oldest expectation
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst[k] && ir_valid[k] && rdy[k] && !fl[k]) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL orphan: inst %0d accepted %h@%h with nothing expected", k, ir_out[k], ir_pc[k]);
            end else begin
               logic [33:0] e;
               e = exp_q.pop_front();
               chk("sb_inst", 32'(k), 32'(e[33:32]));
               chk("sb_ir_out", 32'(ir_out[k]), 32'(e[31:16]));
               chk("sb_ir_pc", 32'(ir_pc[k]), 32'(e[15:0]));
               chk("sb_pc_inc", 32'(pc_inc[k]), 32'd1);
            end
         end
         if (!rst[k] && ram_rd[k]) chk("rd_excl", 32'(ir_valid[k]), 32'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hs[4];
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; fen[k] = 1'b0; fl[k] = 1'b0; rdy[k] = 1'b0;
         pc[k] = 16'h0; pcm[k] = 1'b1;
         for (int a = 0; a < 256; a++) mem[k][a] = 16'hC000 + 16'(a);
      end
      mem[0][8'h00] = 16'h1234;  mem[0][8'h01] = 16'h5678;
      for (int a = 0; a < 4; a++) mem[1][a] = 16'hA000 + 16'(a);
      mem[1][8'hFF] = 16'h7FFF;
      mem[2][8'h20] = 16'hDEAD;  mem[2][8'h40] = 16'hBEEF;
      mem[2][8'h50] = 16'h5555;  mem[2][8'h10] = 16'h1111;

      to_cycle();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ram_rd", 32'(ram_rd[k]), 32'd0);
         chk("rst_ir_valid", 32'(ir_valid[k]), 32'd0);
         chk("rst_ir_out", 32'(ir_out[k]), 32'd0);
      end
      to_cycle();
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;

      // single fetch at L=1, ir_ready high from cycle 0
      to_cycle(); pc[0] = 16'h0000; fen[0] = 1'b1; rdy[0] = 1'b1;
      push(0, 16'h1234, 16'h0000);
      mid(0); chk("t2_c0_rd", 32'(ram_rd[0]), 32'd0);
      to_cycle(); mid(0);
      chk("t2_c1_rd", 32'(ram_rd[0]), 32'd1);
      chk("t2_c1_addr", 32'(ram_addr[0]), 32'h0000);
      to_cycle(); fen[0] = 1'b0; mid(0);
      chk("t2_c2_rd", 32'(ram_rd[0]), 32'd0);
      chk("t2_c2_valid", 32'(ir_valid[0]), 32'd0);
      to_cycle(); mid(0);
      chk("t2_c3_valid", 32'(ir_valid[0]), 32'd1);
      chk("t2_c3_pc_inc", 32'(pc_inc[0]), 32'd1);
      to_cycle(); mid(0);
      chk("t2_c4_pc_inc", 32'(pc_inc[0]), 32'd0);
      chk("t2_c4_valid", 32'(ir_valid[0]), 32'd0);

      // backpressure in HOLD
      chk("t3_pc_model", 32'(pc[0]), 32'h0001);
      to_cycle(); rdy[0] = 1'b0; fen[0] = 1'b1;
      n = 0;
      while (n < 10 && !ir_valid[0]) begin mid(0); n++; if (!ir_valid[0]) to_cycle(); end
      chk("t3_reach_hold", 32'(ir_valid[0]), 32'd1);
      fen[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         to_cycle(); mid(0);
         chk("t3_valid", 32'(ir_valid[0]), 32'd1);
         chk("t3_ir_out", 32'(ir_out[0]), 32'h5678);
         chk("t3_ir_pc", 32'(ir_pc[0]), 32'h0001);
         chk("t3_pc_inc", 32'(pc_inc[0]), 32'd0);
         chk("t3_ram_rd", 32'(ram_rd[0]), 32'd0);
      end
      push(0, 16'h5678, 16'h0001);
      to_cycle(); rdy[0] = 1'b1; mid(0);
      chk("t3_accept", 32'(pc_inc[0]), 32'd1);
      to_cycle(); rdy[0] = 1'b0; mid(0);
      chk("t3_after", 32'(ir_valid[0]), 32'd0);

      // streaming at L=2 with PC model, then wrap 0xFFFF -> 0x0000
      pc[1] = 16'h0000; fen[1] = 1'b1; rdy[1] = 1'b1;
      for (int a = 0; a < 4; a++) push(1, 16'hA000 + 16'(a), 16'(a));
      n = 0;
      for (int c = 1; c <= 40 && n < 4; c++) begin
         to_cycle(); mid(1);
         if (pc_inc[1]) begin hs[n] = c; n++; end
         if (ram_rd[1] && ram_addr[1] == 16'h0003) fen[1] = 1'b0;
      end
      chk("t6_count", 32'(n), 32'd4);
      chk("t6_first", 32'(hs[0]), 32'd4);
      for (int i = 1; i < 4; i++) chk("t6_interval", 32'(hs[i] - hs[i-1]), 32'd4);
      to_cycle(); pc[1] = 16'hFFFF; fen[1] = 1'b1;
      push(1, 16'h7FFF, 16'hFFFF);
      push(1, 16'hA000, 16'h0000);
      n = 0;
      for (int c = 0; c < 30 && n < 2; c++) begin
         mid(1);
         if (pc_inc[1]) n++;
         if (ram_rd[1] && ram_addr[1] == 16'h0000) fen[1] = 1'b0;
         to_cycle();
      end
      chk("wrap_count", 32'(n), 32'd2);
      chk("wrap_pc", 32'(pc[1]), 32'h0001);

      // flush in the 2nd WAIT cycle at L=3
      @(negedge clk); pc[2] = 16'h0020; fen[2] = 1'b1; rdy[2] = 1'b1;
      to_cycle(); mid(2);
      chk("t4_c1_addr", 32'(ram_addr[2]), 32'h0020);
      to_cycle(); mid(2);
      to_cycle(); fl[2] = 1'b1; pc[2] = 16'h0040; mid(2);
      chk("t4_c3_pc_inc", 32'(pc_inc[2]), 32'd0);
      to_cycle(); fl[2] = 1'b0; fen[2] = 1'b0; mid(2);
      chk("t4_c4_rd", 32'(ram_rd[2]), 32'd1);
      chk("t4_c4_addr", 32'(ram_addr[2]), 32'h0040);
      push(2, 16'hBEEF, 16'h0040);
      for (int c = 5; c <= 7; c++) begin
         to_cycle(); mid(2);
         chk("t4_wait_valid", 32'(ir_valid[2]), 32'd0);
      end
      to_cycle(); mid(2);
      chk("t4_c8_valid", 32'(ir_valid[2]), 32'd1);
      chk("t4_c8_ir_out", 32'(ir_out[2]), 32'hBEEF);

      // flush together with ir_ready in HOLD
      to_cycle(); pc[2] = 16'h0050; fen[2] = 1'b1; rdy[2] = 1'b0;
      mid(2);
      for (int c = 1; c <= 4; c++) begin to_cycle(); mid(2); end
      to_cycle(); rdy[2] = 1'b1; fl[2] = 1'b1; mid(2);
      chk("t5_valid", 32'(ir_valid[2]), 32'd1);
      chk("t5_pc_inc", 32'(pc_inc[2]), 32'd0);
      to_cycle(); fl[2] = 1'b0; rdy[2] = 1'b0; mid(2);
      chk("t5_next_valid", 32'(ir_valid[2]), 32'd0);
      chk("t5_refetch_rd", 32'(ram_rd[2]), 32'd1);
      chk("t5_refetch_addr", 32'(ram_addr[2]), 32'h0050);
      push(2, 16'h5555, 16'h0050);
      for (int c = 7; c <= 9; c++) begin to_cycle(); mid(2); end
      to_cycle(); rdy[2] = 1'b1; fen[2] = 1'b0; mid(2);
      chk("t5_valid2", 32'(ir_valid[2]), 32'd1);
      chk("t5_pc_inc2", 32'(pc_inc[2]), 32'd1);
      to_cycle(); rdy[2] = 1'b0; mid(2);

      // asynchronous reset during WAIT at L=3
      pc[2] = 16'h0010; fen[2] = 1'b1;
      to_cycle(); mid(2);
      chk("t1_issue", 32'(ram_rd[2]), 32'd1);
      to_cycle(); mid(2);
      to_cycle(); rst[2] = 1'b1; #1;
      chk("t1_ram_addr", 32'(ram_addr[2]), 32'h0);
      chk("t1_ram_rd", 32'(ram_rd[2]), 32'd0);
      chk("t1_ir_out", 32'(ir_out[2]), 32'h0);
      chk("t1_ir_pc", 32'(ir_pc[2]), 32'h0);
      chk("t1_ir_valid", 32'(ir_valid[2]), 32'd0);
      chk("t1_pc_inc", 32'(pc_inc[2]), 32'd0);
      fen[2] = 1'b0;
      to_cycle(); rst[2] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         to_cycle(); mid(2);
         chk("t1_no_rd", 32'(ram_rd[2]), 32'd0);
      end

      to_cycle();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
